unisr_seq_ctrl: RTL and testbench

//   Command sequencer for the 8-bit universal shift register (mode codes 0 hold, 1 right/sl-in,
//   2 left/sr-in, 3 parallel load). Accepts one command at a time over a valid/ready handshake.

---
 rtl/unisr_seq_ctrl.sv | 140 ++++++++++++++
 tb/tb_unisr_seq_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/unisr_seq_ctrl.sv
// Command sequencer for an 8-bit universal shift register: runs one READ/SHR/SHL/LOAD
// command at a time, streams shifted-out bits and reports the final register contents.
module unisr_seq_ctrl #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [CNT_W-1:0] cmd_cnt,
    input  logic             abort,
    input  logic             ser_in,
    output logic             ser_out,
    output logic             ser_out_valid,
    output logic [1:0]       sr_mode,
    output logic             sr_sl,
    output logic             sr_sr,
    output logic [WIDTH-1:0] sr_par_in,
    input  logic [WIDTH-1:0] sr_par_out,
    output logic             done,
    output logic             done_aborted,
    output logic [WIDTH-1:0] result
);

    localparam logic [1:0] OP_READ  = 2'd0;
    localparam logic [1:0] OP_SHR   = 2'd1;
    localparam logic [1:0] OP_SHL   = 2'd2;
    localparam logic [1:0] OP_LOAD  = 2'd3;
    localparam logic [1:0] MODE_HOLD = 2'd0;
    localparam logic [1:0] MODE_LOAD = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t             state, state_n;
    logic [1:0]         op_r, op_n;
    logic [WIDTH-1:0]   data_r, data_n;
    logic [CNT_W-1:0]   cnt_r, cnt_n;
    logic               aborted_r, aborted_n;

    // State and command registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            op_r      <= 2'd0;
            data_r    <= '0;
            cnt_r     <= '0;
            aborted_r <= 1'b0;
        end else begin
            state     <= state_n;
            op_r      <= op_n;
            data_r    <= data_n;
            cnt_r     <= cnt_n;
            aborted_r <= aborted_n;
        end
    end

    // Next-state and register-side drive; the register is steered combinationally from state
    always_comb begin
        state_n       = state;
        op_n          = op_r;
        data_n        = data_r;
        cnt_n         = cnt_r;
        aborted_n     = aborted_r;
        cmd_ready     = 1'b0;
        sr_mode       = MODE_HOLD;
        sr_sl         = 1'b0;
        sr_sr         = 1'b0;
        sr_par_in     = '0;
        ser_out       = 1'b0;
        ser_out_valid = 1'b0;
        done          = 1'b0;
        done_aborted  = 1'b0;
        result        = '0;

        case (state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    op_n      = cmd_op;
                    data_n    = cmd_data;
                    cnt_n     = cmd_cnt;
                    aborted_n = 1'b0;
                    case (cmd_op)
                        OP_LOAD: state_n = ST_LOAD;
                        OP_SHR,
                        OP_SHL:  state_n = (cmd_cnt != '0) ? ST_SHIFT : ST_DONE;
                        default: state_n = ST_DONE;
                    endcase
                end
            end

            ST_LOAD: begin
                sr_par_in = data_r;
                state_n   = ST_DONE;
                if (abort) begin
                    aborted_n = 1'b1;
                end else begin
                    sr_mode = MODE_LOAD;
                end
            end

            ST_SHIFT: begin
                ser_out = (op_r == OP_SHR) ? sr_par_out[0] : sr_par_out[WIDTH-1];
                sr_sl   = (op_r == OP_SHR) ? ser_in : 1'b0;
                sr_sr   = (op_r == OP_SHL) ? ser_in : 1'b0;
                if (abort) begin
                    // Abort suppresses this cycle's shift edge entirely
                    aborted_n = 1'b1;
                    state_n   = ST_DONE;
                end else begin
                    sr_mode       = op_r;
                    ser_out_valid = 1'b1;
                    cnt_n         = cnt_r - CNT_W'(1);
                    if (cnt_r == CNT_W'(1)) begin
                        state_n = ST_DONE;
                    end
                end
            end

            ST_DONE: begin
                done         = 1'b1;
                done_aborted = aborted_r;
                result       = sr_par_out;
                aborted_n    = 1'b0;
                state_n      = ST_IDLE;
            end

            default: state_n = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_unisr_seq_ctrl.sv
// Scoreboard bench for unisr_seq_ctrl driving a behavioural shift register; expected bits and
// completions come from an arithmetic model of each command.
module tb_unisr_seq_ctrl;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cmd_valid, cmd_ready;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] cmd_data;
    logic [CNT_W-1:0] cmd_cnt;
    logic             abort, ser_in, ser_out, ser_out_valid;
    logic [1:0]       sr_mode;
    logic             sr_sl, sr_sr;
    logic [WIDTH-1:0] sr_par_in, sr_par_out;
    logic             done, done_aborted;
    logic [WIDTH-1:0] result;

    unisr_seq_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_cnt(cmd_cnt), .abort(abort),
        .ser_in(ser_in), .ser_out(ser_out), .ser_out_valid(ser_out_valid),
        .sr_mode(sr_mode), .sr_sl(sr_sl), .sr_sr(sr_sr), .sr_par_in(sr_par_in),
        .sr_par_out(sr_par_out), .done(done), .done_aborted(done_aborted), .result(result)
    );

    always #5 clk = ~clk;

    // The controlled universal shift register (no reset)
    logic [WIDTH-1:0] sreg;
    initial sreg = '0;
    always @(posedge clk) begin
        case (sr_mode)
            2'd1: sreg <= {sr_sl, sreg[WIDTH-1:1]};
            2'd2: sreg <= {sreg[WIDTH-2:0], sr_sr};
            2'd3: sreg <= sr_par_in;
            default: sreg <= sreg;
        endcase
    end
    assign sr_par_out = sreg;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    endfunction

    typedef struct {
        int               at;
        logic [WIDTH-1:0] res;
        logic             ab;
    } done_t;

    done_t exp_done[$];
    bit    exp_bits[$];
    int    ref_val = 0;

    // Monitor: pops expectations whenever the DUT presents a bit or a completion
    always @(negedge clk) begin
        if (rst_n) begin
            if (ser_out_valid) begin
                if (exp_bits.size() == 0) check("ser_out_unexpected", 32'(ser_out_valid), 32'd0);
                else check("ser_out", 32'(ser_out), 32'(exp_bits.pop_front()));
            end
            if (done) begin
                if (exp_done.size() == 0) check("done_unexpected", 32'(done), 32'd0);
                else begin
                    done_t e;
                    e = exp_done.pop_front();
                    check("done_latency", 32'(cyc), 32'(e.at));
                    check("result", 32'(result), 32'(e.res));
                    check("done_aborted", 32'(done_aborted), 32'(e.ab));
                end
            end
        end
    end

    // Called and returning at posedge+1: issue one command, push its expectations, drive its cycles
    task automatic run_cmd(input logic [1:0] op, input logic [WIDTH-1:0] data,
                           input logic [CNT_W-1:0] cnt, input int abort_at, input logic [15:0] fill);
        int w, a, spent, shifts, v;
        bit ab;
        done_t e;
        w = 0;
        while (!cmd_ready && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        if (!cmd_ready) begin
            check("ready_timeout", 32'(cmd_ready), 32'd1);
            return;
        end
        v = ref_val;
        spent = 0;
        ab = 1'b0;
        if (op == 2'd3) begin
            spent = 1;
            ab = (abort_at == 1);
            if (!ab) v = int'(data);
        end else if (op != 2'd0 && cnt != 0) begin
            ab = (abort_at >= 1 && abort_at <= int'(cnt));
            spent  = ab ? abort_at : int'(cnt);
            shifts = ab ? abort_at - 1 : int'(cnt);
            for (int i = 0; i < shifts; i++) begin
                if (op == 2'd1) begin
                    exp_bits.push_back(bit'(v % 2));
                    v = v / 2 + int'(fill[i]) * 128;
                end else begin
                    exp_bits.push_back(bit'(v / 128));
                    v = (v * 2) % 256 + int'(fill[i]);
                end
            end
        end
        ref_val = v;

        cmd_valid = 1'b1;
        cmd_op = op;
        cmd_data = data;
        cmd_cnt = cnt;
        @(posedge clk); #1;
        a = cyc;
        e.at = a + spent;
        e.res = WIDTH'(v);
        e.ab = ab;
        exp_done.push_back(e);
        cmd_valid = 1'b0;
        cmd_op = 2'($urandom);
        cmd_data = WIDTH'($urandom);
        cmd_cnt = CNT_W'($urandom);

        for (int i = 0; i < spent; i++) begin
            ser_in = (op == 2'd3) ? 1'($urandom) : fill[i];
            abort = (i + 1 == abort_at);
            @(negedge clk);
            check("sr_mode", 32'(sr_mode), abort ? 32'd0 : 32'(op));
            check("ready_busy", 32'(cmd_ready), 32'd0);
            @(posedge clk); #1;
        end
        abort = 1'b0;
        ser_in = 1'($urandom);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_checks);
        $fatal(1);
    end

    initial begin
        int ab_at;
        logic [1:0] op;
        logic [CNT_W-1:0] cnt;
        rst_n = 1'b0;
        cmd_valid = 1'b0; cmd_op = '0; cmd_data = '0; cmd_cnt = '0;
        abort = 1'b0; ser_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 32'(cmd_ready), 32'd1);
        check("rst_mode", 32'(sr_mode), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_valid", 32'(ser_out_valid), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_cmd(2'd3, 8'hA5, 4'd0, 0, 16'h0);
        run_cmd(2'd3, 8'h81, 4'd0, 0, 16'h0);
        run_cmd(2'd1, 8'h00, 4'd3, 0, 16'b101);
        run_cmd(2'd3, 8'h81, 4'd0, 0, 16'h0);
        run_cmd(2'd2, 8'h00, 4'd2, 0, 16'b11);
        run_cmd(2'd1, 8'hFF, 4'd0, 0, 16'hFFFF);
        run_cmd(2'd0, 8'hFF, 4'd9, 0, 16'hFFFF);
        run_cmd(2'd3, 8'h5A, 4'd0, 0, 16'h0);
        run_cmd(2'd2, 8'h00, 4'd12, 0, 16'h0);
        run_cmd(2'd3, 8'hC3, 4'd0, 0, 16'h0);
        run_cmd(2'd1, 8'h00, 4'd5, 2, 16'h1F);
        run_cmd(2'd3, 8'h11, 4'd0, 1, 16'h0);

        for (int k = 0; k < 50; k++) begin
            op = 2'($urandom);
            cnt = CNT_W'($urandom);
            ab_at = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 15) : 0;
            run_cmd(op, WIDTH'($urandom), cnt, ab_at, 16'($urandom));
        end

        // Async reset while a LOAD is in flight: no load edge, no done
        while (!cmd_ready) begin @(posedge clk); #1; end
        cmd_valid = 1'b1; cmd_op = 2'd3; cmd_data = 8'h3C; cmd_cnt = '0;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("rst_mid_mode", 32'(sr_mode), 32'd0);
        check("rst_mid_ready", 32'(cmd_ready), 32'd1);
        check("rst_mid_done", 32'(done), 32'd0);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        run_cmd(2'd0, 8'h00, 4'd0, 0, 16'h0);

        repeat (4) @(posedge clk);
        check("pending_done", 32'(exp_done.size()), 32'd0);
        check("pending_bits", 32'(exp_bits.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
